clock_period_meter: RTL and testbench
=====================================

Name: clock_period_meter

Overview:
- Measures a slow, divided clock (e.g. a divide-by-4 clock_out) back in the fast domain that generated it.
- Synchronizes the incoming signal and detects its edges; reports high time, low time and period in clock_in cycles.
- Flags periods outside an expected window and asserts a lock indication after consecutive good periods.
- Sits beside the clock divider as its checker; also serves as a general frequency monitor on the lab board.

Parameters:
- CNT_W, 16: width of high/low counters; period output is CNT_W+1 bits.
- SYNC_STAGES, 2: synchronizer flops on sig_in (min 2).
- EXP_PERIOD, 4: expected period in clock_in cycles.
- TOL, 0: allowed +/- deviation from EXP_PERIOD, inclusive.
- LOCK_COUNT, 4: consecutive in-window periods required for locked.

Ports:
- clock_in  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- enable  input  1  measurement enable
- sig_in  input  1  measured signal, possibly asynchronous
- high_time  output  CNT_W  cycles from last rise to following fall
- low_time  output  CNT_W  cycles from last fall to following rise
- period  output  CNT_W+1  high_time + low_time of last complete cycle
- valid  output  1  one-cycle pulse when high/low/period update
- error  output  1  one-cycle pulse with valid when period is out of window
- timeout  output  1  one-cycle pulse when a counter saturates
- locked  output  1  level, LOCK_COUNT consecutive good periods seen

Behaviour:
- Interface: one clock (clock_in); reset is synchronous and active-high.
- Reset: all outputs 0, synchronizer and edge-history flops 0, counters 0, good_cnt 0, state IDLE.
- sig_s is the last synchronizer stage. rise = sig_s & ~sig_d; fall = ~sig_s & sig_d; sig_d is sig_s delayed one cycle. Detection latency is SYNC_STAGES+1 cycles from sig_in; measured durations are unaffected.
- FSM states: IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW.
- IDLE: counters held. Go to WAIT_RISE when enable=1.
- WAIT_RISE: discards partial cycles. On rise: cnt<=1, go to MEAS_HIGH.
- MEAS_HIGH: each cycle without an edge, cnt<=cnt+1. On fall: high_reg<=cnt, cnt<=1, go to MEAS_LOW.
- MEAS_LOW: each cycle without an edge, cnt<=cnt+1. On rise:
  - high_time<=high_reg, low_time<=cnt, period<=high_reg+cnt (zero-extended), valid<=1.
  - cnt<=1; stay in MEAS_LOW's successor, MEAS_HIGH.
- Error/lock evaluation, in the same cycle as valid:
  - Period outside [EXP_PERIOD-TOL, EXP_PERIOD+TOL] (lower bound clamped at 0): error<=1, good_cnt<=0, locked<=0.
  - Otherwise good_cnt increments, saturating at LOCK_COUNT; locked<=1 when good_cnt reaches LOCK_COUNT.
- Timeout: if cnt == all-ones in MEAS_HIGH or MEAS_LOW with no edge:
  - timeout pulse, locked<=0, good_cnt<=0, go to WAIT_RISE.
  - No valid; high/low/period keep their old values.
- enable deasserted in any state:
  - Next state IDLE; locked<=0, good_cnt<=0.
  - Measurement outputs hold their last values; an edge in that cycle is ignored.
- reset mid-measurement: takes priority over everything; behaves as at power-up.
- valid, error and timeout are never asserted for more than one cycle; error implies valid; timeout and valid are mutually exclusive.

Decomposition:
- Shared package: FSM state encoding constants (IDLE/WAIT_RISE/MEAS_HIGH/MEAS_LOW), default CNT_W.
- Sub-module sync_edge_detect (parameter SYNC_STAGES): synchronizer chain plus rise/fall pulse outputs. Reusable by other lab blocks with async inputs.

Test Plan:
- Divide-by-4 stream (sig_in toggles every 2 cycles), enable=1 → valid every 4 cycles with high=2, low=2, period=4, error=0; locked=1 on the 4th valid.
- Drive sig_in high for 3 cycles, low for 2 (EXP_PERIOD=4, TOL=0) → valid with high=3, low=2, period=5, error=1 in the same cycle; locked drops to 0.
- Lock, then hold sig_in low with CNT_W=4 → timeout pulse when low count hits 15; locked=0; FSM back to WAIT_RISE; next full cycle yields valid with period=4.
- Deassert enable mid-MEAS_HIGH for 5 cycles, then reassert → no valid while disabled; first valid only after a full rise-fall-rise; outputs retain pre-disable values until then.
- Assert reset for 1 cycle mid-MEAS_LOW → next cycle all outputs 0 and state IDLE; measurement resumes from WAIT_RISE, no spurious valid.
- TOL=1, periods of 3, 5, 4, 6 cycles → error pulses only on period 6; good_cnt resets at that point, and locked stays 0 throughout.

Source files
------------

// File: rtl/clock_period_meter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : clock_period_meter_pkg                                |
// | Brief    : Shared FSM state encoding and default counter width   |
// |            for the clock period meter.                           |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
package clock_period_meter_pkg;

  // Default width of the high/low duration counters.
  localparam int c_CNT_W_DEFAULT = 16;

  // Measurement FSM states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : sync_edge_detect                                      |
// | Brief    : Multi-flop synchronizer for an asynchronous input     |
// |            followed by single-cycle rise and fall pulses.        |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module sync_edge_detect
  import clock_period_meter_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sig_d;
  logic                   w_sig_s;

  assign w_sig_s = r_sync[SYNC_STAGES-1];

  // Shift the raw input through the synchronizer and keep one cycle of history.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= '0;
      r_sig_d <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_sig};
      r_sig_d <= w_sig_s;
    end
  end

  assign o_rise = w_sig_s & ~r_sig_d;
  assign o_fall = ~w_sig_s & r_sig_d;

endmodule
`default_nettype wire

// File: rtl/clock_period_meter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : clock_period_meter                                    |
// | Brief    : Measures high time, low time and period of a slow     |
// |            signal in clock_in cycles; flags out-of-window        |
// |            periods, counter timeouts and lock.                   |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module clock_period_meter
  import clock_period_meter_pkg::*;
#(
  parameter int CNT_W       = c_CNT_W_DEFAULT,
  parameter int SYNC_STAGES = 2,
  parameter int EXP_PERIOD  = 4,
  parameter int TOL         = 0,
  parameter int LOCK_COUNT  = 4
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] low_time,
  output logic [CNT_W:0]   period,
  output logic             valid,
  output logic             error,
  output logic             timeout,
  output logic             locked
);

  localparam int c_GOOD_W = $clog2(LOCK_COUNT + 1);
  // Lower window bound clamps at zero when the tolerance exceeds the target.
  localparam int c_LO_INT = (EXP_PERIOD > TOL) ? (EXP_PERIOD - TOL) : 0;
  localparam logic [CNT_W:0]        c_LO   = (CNT_W+1)'(c_LO_INT);
  localparam logic [CNT_W:0]        c_HI   = (CNT_W+1)'(EXP_PERIOD + TOL);
  localparam logic [c_GOOD_W-1:0]   c_LOCK = c_GOOD_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0]      c_ONE  = CNT_W'(1);

  logic w_rise, w_fall;

  state_t              r_state, w_state_n;
  logic [CNT_W-1:0]    r_cnt, w_cnt_n;
  logic [CNT_W-1:0]    r_high, w_high_n;
  logic [c_GOOD_W-1:0] r_good, w_good_n, w_good_inc;
  logic [CNT_W-1:0]    r_high_time, w_high_time_n;
  logic [CNT_W-1:0]    r_low_time, w_low_time_n;
  logic [CNT_W:0]      r_period, w_period_n;
  logic                r_valid, w_valid_n;
  logic                r_error, w_error_n;
  logic                r_timeout, w_timeout_n;
  logic                r_locked, w_locked_n;
  logic [CNT_W:0]      w_period_sum;
  logic                w_in_window;
  logic                w_to;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clock_in),
    .rst    (reset),
    .i_sig  (sig_in),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  assign w_period_sum = {1'b0, r_high} + {1'b0, r_cnt};
  assign w_in_window  = (w_period_sum >= c_LO) && (w_period_sum <= c_HI);
  assign w_good_inc   = (r_good == c_LOCK) ? r_good : r_good + 1'b1;

  // Next-state, counter and result logic; results hold unless updated.
  always_comb begin
    w_state_n     = r_state;
    w_cnt_n       = r_cnt;
    w_high_n      = r_high;
    w_good_n      = r_good;
    w_locked_n    = r_locked;
    w_high_time_n = r_high_time;
    w_low_time_n  = r_low_time;
    w_period_n    = r_period;
    w_valid_n     = 1'b0;
    w_error_n     = 1'b0;
    w_timeout_n   = 1'b0;
    w_to          = 1'b0;
    if (!enable) begin
      // Disabling abandons the measurement and drops lock; edges are ignored.
      w_state_n  = IDLE;
      w_good_n   = '0;
      w_locked_n = 1'b0;
    end else begin
      case (r_state)
        IDLE: w_state_n = WAIT_RISE;
        WAIT_RISE: begin
          // Only a rising edge starts a measurement, so partial cycles are dropped.
          if (w_rise) begin
            w_cnt_n   = c_ONE;
            w_state_n = MEAS_HIGH;
          end
        end
        MEAS_HIGH: begin
          if (w_fall) begin
            w_high_n  = r_cnt;
            w_cnt_n   = c_ONE;
            w_state_n = MEAS_LOW;
          end else if (&r_cnt) begin
            w_to = 1'b1;
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end
        MEAS_LOW: begin
          if (w_rise) begin
            w_high_time_n = r_high;
            w_low_time_n  = r_cnt;
            w_period_n    = w_period_sum;
            w_valid_n     = 1'b1;
            w_cnt_n       = c_ONE;
            w_state_n     = MEAS_HIGH;
            if (w_in_window) begin
              w_good_n = w_good_inc;
              if (w_good_inc == c_LOCK) begin
                w_locked_n = 1'b1;
              end
            end else begin
              w_error_n  = 1'b1;
              w_good_n   = '0;
              w_locked_n = 1'b0;
            end
          end else if (&r_cnt) begin
            w_to = 1'b1;
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end
        default: w_state_n = IDLE;
      endcase
      // A saturated counter means the signal stalled: restart from the next rise.
      if (w_to) begin
        w_timeout_n = 1'b1;
        w_good_n    = '0;
        w_locked_n  = 1'b0;
        w_state_n   = WAIT_RISE;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // Counters, lock tracking and registered outputs.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_cnt       <= '0;
      r_high      <= '0;
      r_good      <= '0;
      r_high_time <= '0;
      r_low_time  <= '0;
      r_period    <= '0;
      r_valid     <= 1'b0;
      r_error     <= 1'b0;
      r_timeout   <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_n;
      r_high      <= w_high_n;
      r_good      <= w_good_n;
      r_high_time <= w_high_time_n;
      r_low_time  <= w_low_time_n;
      r_period    <= w_period_n;
      r_valid     <= w_valid_n;
      r_error     <= w_error_n;
      r_timeout   <= w_timeout_n;
      r_locked    <= w_locked_n;
    end
  end

  assign high_time = r_high_time;
  assign low_time  = r_low_time;
  assign period    = r_period;
  assign valid     = r_valid;
  assign error     = r_error;
  assign timeout   = r_timeout;
  assign locked    = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_clock_period_meter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_clock_period_meter                                 |
// | Brief    : Scoreboard bench for clock_period_meter; two meters   |
// |            with different window/width settings share stimulus.  |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module tb_clock_period_meter;

  localparam int EXP = 4;

  logic clock_in = 1'b0;
  logic reset    = 1'b1;
  logic enable   = 1'b0;
  logic sig_in   = 1'b0;

  always #5 clock_in = ~clock_in;

  // Meter A: 4-bit counters, exact window. Meter B: 5-bit counters, +/-1 window.
  logic [3:0] a_high, a_low;
  logic [4:0] a_period;
  logic       a_valid, a_error, a_timeout, a_locked;
  logic [4:0] b_high, b_low;
  logic [5:0] b_period;
  logic       b_valid, b_error, b_timeout, b_locked;

  clock_period_meter #(.CNT_W(4), .SYNC_STAGES(2), .EXP_PERIOD(EXP), .TOL(0), .LOCK_COUNT(4)) dut_a (
    .clock_in(clock_in), .reset(reset), .enable(enable), .sig_in(sig_in),
    .high_time(a_high), .low_time(a_low), .period(a_period), .valid(a_valid),
    .error(a_error), .timeout(a_timeout), .locked(a_locked)
  );

  clock_period_meter #(.CNT_W(5), .SYNC_STAGES(2), .EXP_PERIOD(EXP), .TOL(1), .LOCK_COUNT(4)) dut_b (
    .clock_in(clock_in), .reset(reset), .enable(enable), .sig_in(sig_in),
    .high_time(b_high), .low_time(b_low), .period(b_period), .valid(b_valid),
    .error(b_error), .timeout(b_timeout), .locked(b_locked)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic        to;
    logic [15:0] h;
    logic [15:0] l;
    logic [16:0] p;
    logic        er;
    logic        lk;
  } ev_t;

  // Reference state: the synchronized level is modelled as the input delayed
  // two cycles; run = length of the current synchronized level so far.
  typedef struct packed {
    int         maxc;
    int         tol;
    int         run;
    int         en_age;
    int         phase;   // 0 not measuring, 1 timing high, 2 timing low
    int         hcap;
    int         good;
    logic       lk;
    int         lh;
    int         ll;
    int         lp;
    logic [2:0] pipe;
  } mdl_t;

  ev_t  exp_q [2][$];
  mdl_t md [2];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  bit   rst_pending = 1'b0;

  always @(posedge clock_in) cyc <= cyc + 1;

  task automatic model_step(input int k, input int m, input bit lvl, input bit en, input bit rs);
    bit  s, sp, chg;
    int  p;
    ev_t ev;
    s   = md[k].pipe[1];
    sp  = md[k].pipe[2];
    chg = (s != sp);
    if (rs) begin
      md[k].pipe = '0; md[k].run = 0; md[k].en_age = 0; md[k].phase = 0;
      md[k].good = 0;  md[k].lk = 1'b0;
      md[k].lh = 0; md[k].ll = 0; md[k].lp = 0;
      return;
    end
    if (!en) begin
      md[k].en_age = 0; md[k].phase = 0; md[k].good = 0; md[k].lk = 1'b0;
    end else begin
      md[k].en_age = md[k].en_age + 1;
      if (md[k].en_age >= 2) begin
        if (md[k].phase == 0) begin
          if (s && !sp) md[k].phase = 1;
        end else if (chg && md[k].phase == 1) begin
          md[k].hcap  = md[k].run;
          md[k].phase = 2;
        end else if (chg) begin
          p = md[k].hcap + md[k].run;
          ev.er = ((p - EXP) > md[k].tol) || ((EXP - p) > md[k].tol);
          if (ev.er) begin
            md[k].good = 0; md[k].lk = 1'b0;
          end else begin
            if (md[k].good < 4) md[k].good = md[k].good + 1;
            if (md[k].good >= 4) md[k].lk = 1'b1;
          end
          md[k].lh = md[k].hcap; md[k].ll = md[k].run; md[k].lp = p;
          ev.cyc = 32'(m); ev.to = 1'b0;
          ev.h = 16'(md[k].lh); ev.l = 16'(md[k].ll); ev.p = 17'(md[k].lp);
          ev.lk = md[k].lk;
          exp_q[k].push_back(ev);
          md[k].phase = 1;
        end else if (md[k].run >= md[k].maxc) begin
          md[k].good = 0; md[k].lk = 1'b0; md[k].phase = 0;
          ev.cyc = 32'(m); ev.to = 1'b1; ev.er = 1'b0; ev.lk = 1'b0;
          ev.h = 16'(md[k].lh); ev.l = 16'(md[k].ll); ev.p = 17'(md[k].lp);
          exp_q[k].push_back(ev);
        end
      end
    end
    md[k].run  = chg ? 1 : md[k].run + 1;
    md[k].pipe = {md[k].pipe[1:0], lvl};
  endtask

  task automatic mon(input int k, input logic v, input logic e, input logic t,
                     input logic [15:0] h, input logic [15:0] l, input logic [16:0] p, input logic lk);
    ev_t got, ex;
    n_checks++;
    if ((e === 1'b1 && v !== 1'b1) || (v === 1'b1 && t === 1'b1)) begin
      n_err++;
      $display("FAIL pulse_rules dut%0d cyc=%0d: valid=%b error=%b timeout=%b (need error->valid, not valid&timeout)",
               k, cyc, v, e, t);
    end
    if (v === 1'b1 || t === 1'b1) begin
      got = '{cyc: 32'(cyc), to: t, h: h, l: l, p: p, er: e, lk: lk};
      n_checks++;
      if (exp_q[k].size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event dut%0d: got cyc=%0d to=%b h=%0d l=%0d p=%0d err=%b lk=%b, required none",
                 k, cyc, t, h, l, p, e, lk);
      end else begin
        ex = exp_q[k].pop_front();
        if (got !== ex) begin
          n_err++;
          $display("FAIL event dut%0d: got cyc=%0d to=%b h=%0d l=%0d p=%0d err=%b lk=%b, required cyc=%0d to=%b h=%0d l=%0d p=%0d err=%b lk=%b",
                   k, got.cyc, got.to, got.h, got.l, got.p, got.er, got.lk,
                   ex.cyc, ex.to, ex.h, ex.l, ex.p, ex.er, ex.lk);
        end
      end
    end
  endtask

  // Monitor: outputs registered at posedge are sampled on the following negedge.
  always @(negedge clock_in) begin
    mon(0, a_valid, a_error, a_timeout, 16'(a_high), 16'(a_low), 17'(a_period), a_locked);
    mon(1, b_valid, b_error, b_timeout, 16'(b_high), 16'(b_low), 17'(b_period), b_locked);
  end

  task automatic check_zero();
    n_checks++;
    if ({a_high, a_low, a_period, a_valid, a_error, a_timeout, a_locked} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs dut0: got h=%0d l=%0d p=%0d v=%b e=%b t=%b lk=%b, required all 0",
               a_high, a_low, a_period, a_valid, a_error, a_timeout, a_locked);
    end
    n_checks++;
    if ({b_high, b_low, b_period, b_valid, b_error, b_timeout, b_locked} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs dut1: got h=%0d l=%0d p=%0d v=%b e=%b t=%b lk=%b, required all 0",
               b_high, b_low, b_period, b_valid, b_error, b_timeout, b_locked);
    end
  endtask

  // One clock of stimulus: inputs change on the negedge ahead of the posedge they feed.
  task automatic seg(input bit lvl, input int n, input bit en, input bit rs);
    for (int i = 0; i < n; i++) begin
      @(negedge clock_in);
      if (rst_pending) check_zero();
      sig_in = lvl;
      enable = en;
      reset  = rs;
      model_step(0, cyc + 1, lvl, en, rs);
      model_step(1, cyc + 1, lvl, en, rs);
      rst_pending = rs;
    end
  endtask

  task automatic div4(input int n);
    for (int i = 0; i < n; i++) begin
      seg(1'b1, 2, 1'b1, 1'b0);
      seg(1'b0, 2, 1'b1, 1'b0);
    end
  endtask

  initial begin
    int h, l, r;
    md[0] = '0; md[0].maxc = 15; md[0].tol = 0;
    md[1] = '0; md[1].maxc = 31; md[1].tol = 1;

    seg(1'b0, 3, 1'b0, 1'b1);          // power-up reset
    seg(1'b0, 2, 1'b1, 1'b0);
    div4(12);                          // steady divide-by-4, lock on 4th result
    seg(1'b1, 3, 1'b1, 1'b0);          // 3 high / 2 low: period 5
    seg(1'b0, 2, 1'b1, 1'b0);
    div4(5);
    seg(1'b0, 20, 1'b1, 1'b0);         // stalled low: 4-bit meter times out
    div4(6);
    seg(1'b1, 1, 1'b1, 1'b0);          // enable dropped mid-high for 5 cycles
    seg(1'b1, 1, 1'b0, 1'b0);
    seg(1'b0, 2, 1'b0, 1'b0);
    seg(1'b1, 2, 1'b0, 1'b0);
    seg(1'b1, 1, 1'b1, 1'b0);
    seg(1'b0, 2, 1'b1, 1'b0);
    div4(6);
    div4(3);                           // reset pulse mid-low
    seg(1'b0, 1, 1'b1, 1'b0);
    seg(1'b0, 1, 1'b1, 1'b1);
    seg(1'b0, 1, 1'b1, 1'b0);
    div4(6);
    seg(1'b1, 1, 1'b0, 1'b0);          // unlock, then periods 3, 5, 4, 6
    seg(1'b0, 3, 1'b1, 1'b0);
    seg(1'b1, 2, 1'b1, 1'b0); seg(1'b0, 1, 1'b1, 1'b0);
    seg(1'b1, 3, 1'b1, 1'b0); seg(1'b0, 2, 1'b1, 1'b0);
    seg(1'b1, 2, 1'b1, 1'b0); seg(1'b0, 2, 1'b1, 1'b0);
    seg(1'b1, 3, 1'b1, 1'b0); seg(1'b0, 3, 1'b1, 1'b0);
    seg(1'b1, 2, 1'b1, 1'b0); seg(1'b0, 2, 1'b1, 1'b0);

    for (int i = 0; i < 200; i++) begin
      r = int'($urandom_range(0, 29));
      if ($urandom_range(0, 1) == 0) begin
        h = 2; l = 2;
      end else begin
        h = int'($urandom_range(1, 6));
        l = int'($urandom_range(1, 6));
      end
      if (r == 0) l = int'($urandom_range(16, 20));
      if (r == 1) h = int'($urandom_range(16, 34));
      seg(1'b1, h, 1'b1, 1'b0);
      if (r == 2) seg(1'b1, int'($urandom_range(1, 4)), 1'b0, 1'b0);
      if (r == 3) seg(1'b0, 1, 1'b1, 1'b1);
      seg(1'b0, l, 1'b1, 1'b0);
    end

    seg(1'b0, 6, 1'b0, 1'b0);          // quiet tail so every expected event drains
    @(negedge clock_in);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (exp_q[k].size() != 0) begin
        n_err++;
        $display("FAIL missing_events dut%0d: %0d expected events never seen, required 0",
                 k, exp_q[k].size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
